// File: rtl/busint_test_target_if.sv
// CPU busint request/response bundle between the test CPU and its bus-side responder.
interface busint_test_target_if;
    logic        memrq;
    logic        memwr;
    logic [21:0] addr;
    logic [31:0] busout;
    logic        memack;
    logic        memdone;
    logic [31:0] busin;

    modport master (
        output memrq, memwr, addr, busout,
        input  memack, memdone, busin
    );

    modport slave (
        input  memrq, memwr, addr, busout,
        output memack, memdone, busin
    );
endinterface

// File: rtl/busint_test_target.sv
// Bus-side responder for the peripheral-test CPU: a RAM window plus an emulated
// disk-controller register block, answered with a fixed-latency memack/memdone handshake.
module busint_test_target #(
    parameter int unsigned MEM_AW           = 8,
    parameter logic [21:0] MEM_BASE         = 22'h011000,
    parameter logic [21:0] DSK_BASE         = 22'o17377770,
    parameter int unsigned ACK_DELAY        = 2,
    parameter int unsigned DISK_BUSY_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    busint_test_target_if.slave       busint,
    output logic [31:0]               disk_cmd,
    output logic [31:0]               disk_clp,
    output logic [31:0]               disk_da,
    output logic [7:0]                disk_ops,
    output logic                      bad_addr
);

    localparam logic [3:0] DelayInit = 4'(ACK_DELAY);
    localparam logic [7:0] BusyInit  = 8'(DISK_BUSY_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StResp, StRecover} state_e;

    state_e        state_q, state_d;
    logic [3:0]    dly_q, dly_d;
    logic [21:0]   addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          memack_q, memack_d;
    logic          memdone_q, memdone_d;
    logic [31:0]   busin_q, busin_d;
    logic          bad_q, bad_d;
    logic [31:0]   cmd_q, cmd_d, clp_q, clp_d, da_q, da_d;
    logic [7:0]    busy_q, busy_d;
    logic [7:0]    ops_q, ops_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [2**MEM_AW];

    logic              ram_hit, dsk_hit;
    logic [MEM_AW-1:0] ram_idx;
    logic [2:0]        reg_off;
    logic [31:0]       rdata;
    logic              wr_fire, ram_we, go_wr;

    // Address decode of the latched request and read-data mux.
    always_comb begin
        ram_hit = (addr_q[21:MEM_AW] == MEM_BASE[21:MEM_AW]);
        dsk_hit = (addr_q[21:3] == DSK_BASE[21:3]);
        ram_idx = addr_q[MEM_AW-1:0];
        reg_off = addr_q[2:0];
        rdata   = 32'h0;
        if (ram_hit) begin
            rdata = mem_q[ram_idx];
        end else if (dsk_hit) begin
            case (reg_off)
                3'd0:    rdata = {16'h0, ops_q, 6'h0, err_q, ready_q};
                3'd4:    rdata = cmd_q;
                3'd5:    rdata = clp_q;
                3'd6:    rdata = da_q;
                default: rdata = 32'h0;
            endcase
        end
        wr_fire = (state_q == StResp) && wr_q;
        ram_we  = wr_fire && ram_hit;
        go_wr   = wr_fire && dsk_hit && (reg_off == 3'd7);
    end

    // Bus FSM next state; responses are computed one cycle early so they leave flops.
    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        memack_d  = 1'b0;
        memdone_d = 1'b0;
        busin_d   = busin_q;
        bad_d     = bad_q | ((state_q == StResp) && !ram_hit && !dsk_hit);
        unique case (state_q)
            StIdle: begin
                if (busint.memrq) begin
                    addr_d  = busint.addr;
                    wr_d    = busint.memwr;
                    wdata_d = busint.busout;
                    dly_d   = DelayInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (dly_q == 4'd0) begin
                    state_d  = StResp;
                    memack_d = 1'b1;
                    if (!wr_q) begin
                        memdone_d = 1'b1;
                        busin_d   = rdata;
                    end
                end else begin
                    dly_d = dly_q - 4'd1;
                end
            end
            StResp: state_d = StRecover;
            StRecover: begin
                // memrq must drop before the next request is taken.
                if (!busint.memrq) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Disk engine: completion is applied before a GO landing on the same edge.
    always_comb begin
        cmd_d   = cmd_q;
        clp_d   = clp_q;
        da_d    = da_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        err_d   = err_q;
        ops_d   = ops_q;
        if (wr_fire && dsk_hit && reg_off == 3'd4) cmd_d = wdata_q;
        if (wr_fire && dsk_hit && reg_off == 3'd5) clp_d = wdata_q;
        if (wr_fire && dsk_hit && reg_off == 3'd6) da_d  = wdata_q;
        if (busy_q != 8'd0) begin
            busy_d = busy_q - 8'd1;
            if (busy_q == 8'd1) begin
                ready_d = 1'b1;
                ops_d   = ops_q + 8'd1;
            end
        end
        if (go_wr) begin
            if (ready_d) begin
                ready_d = 1'b0;
                err_d   = 1'b0;
                busy_d  = BusyInit;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            dly_q     <= 4'd0;
            addr_q    <= 22'd0;
            wr_q      <= 1'b0;
            wdata_q   <= 32'h0;
            memack_q  <= 1'b0;
            memdone_q <= 1'b0;
            busin_q   <= 32'h0;
            bad_q     <= 1'b0;
            cmd_q     <= 32'h0;
            clp_q     <= 32'h0;
            da_q      <= 32'h0;
            busy_q    <= 8'd0;
            ready_q   <= 1'b1;
            err_q     <= 1'b0;
            ops_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            memack_q  <= memack_d;
            memdone_q <= memdone_d;
            busin_q   <= busin_d;
            bad_q     <= bad_d;
            cmd_q     <= cmd_d;
            clp_q     <= clp_d;
            da_q      <= da_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            ops_q     <= ops_d;
        end
    end

    // Backing RAM; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) mem_q[ram_idx] <= wdata_q;
    end

    assign busint.memack  = memack_q;
    assign busint.memdone = memdone_q;
    assign busint.busin   = busin_q;
    assign disk_cmd       = cmd_q;
    assign disk_clp       = clp_q;
    assign disk_da        = da_q;
    assign disk_ops       = ops_q;
    assign bad_addr       = bad_q;

endmodule

// File: doc/busint_test_target.md
# busint_test_target

Bus-side responder for the microcoded peripheral-test CPU. It sits directly downstream of the CPU's busint port: it services each memrq/memwr request, answering with memack and memdone. Requests decode either to a small backing RAM window or to an emulated disk-controller register block. This lets the CPU's fill / disk-command / poll / compare microprogram run standalone in simulation and on the board.

## Interface
Parameters:
- MEM_AW, 8: RAM address width (2^MEM_AW 32-bit words).
- MEM_BASE, 22'h011000: word address of RAM word 0; must be aligned to 2^MEM_AW.
- DSK_BASE, 22'o17377770: base of the 8-word disk register block.
- ACK_DELAY, 2: extra wait cycles before a response (0..15).
- DISK_BUSY_CYCLES, 16: busy time of a disk operation (1..255).

Ports:
- clk  in  1  sole clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- busint_memrq  in  1  request level from CPU.
- busint_memwr  in  1  1 = write, 0 = read; sampled with memrq.
- busint_addr  in  22  word address.
- busint_busout  in  32  write data from CPU.
- busint_memack  out  1  one-cycle acknowledge.
- busint_memdone  out  1  one-cycle read-complete; busin valid this cycle.
- busint_busin  out  32  read data to CPU.
- disk_cmd  out  32  last value written to the CMD register.
- disk_clp  out  32  last value written to the CLP register.
- disk_da  out  32  last value written to the DA register.
- disk_ops  out  8  completed disk operations, wraps 255->0.
- bad_addr  out  1  sticky; set by any access to an unmapped address.

## Operation
- Decode: RAM if addr[21:MEM_AW] == MEM_BASE[21:MEM_AW]. DSK if addr[21:3] == DSK_BASE[21:3]. Otherwise unmapped.
- DSK register offsets:
  - 0 STATUS (read-only): bit0 ready, bit1 err, bits[15:8] disk_ops, other bits 0.
  - 4 CMD.
  - 5 CLP.
  - 6 DA.
  - 7 GO: write-only; reads return 0.
  - Offsets 1-3: reads return 0; writes are ignored. These are mapped, so bad_addr is not set.
- Bus FSM states: IDLE, WAIT, RESP, RECOVER.
  - IDLE: on memrq=1, latch addr, wr and busout. Load the delay counter with ACK_DELAY. Go to WAIT.
  - WAIT: decrement the counter; at 0 go to RESP. With ACK_DELAY=0, WAIT lasts one cycle.
  - RESP (one cycle):
    - Write: assert memack. RAM or register updates on the closing edge.
    - Read: assert memack and memdone together, with busin driven from the latched address.
    - Go to RECOVER.
  - RECOVER: wait for memrq=0 (minimum one cycle), then return to IDLE. A request is never serviced twice. memrq must drop between accesses.
- memrq falling before RESP: the transaction still completes; the response is issued regardless.
- busin holds the last read value until the next read response.
- Unmapped access: a write is acknowledged and discarded; a read returns 0 with memdone. Both set bad_addr, which is cleared only by reset.
- Disk engine:
  - Reset state: ready=1, err=0, busy counter 0.
  - GO write while ready: clear ready and err, load busy counter with DISK_BUSY_CYCLES.
  - Counter decrements each cycle. On reaching 0: set ready, increment disk_ops.
  - GO write while busy: ignored (counter not reloaded), set err.
  - CMD/CLP/DA writes are accepted at any time.
- The engine runs concurrently with the bus FSM. A STATUS read during busy returns bit0=0.

## Timing
- Let cycle 0 be the first cycle memrq=1 is seen in IDLE. The response is asserted during cycle ACK_DELAY+2. With default ACK_DELAY=2, that is cycle 4.
- All outputs are registered.
- GO completion: the GO write takes effect on the RESP closing edge E. ready reads 1 from cycle E+DISK_BUSY_CYCLES onward; disk_ops increments on that same edge.
- Simultaneous: if completion and a GO write land on the same edge, completion is applied first, then the new GO is accepted as a ready GO.
- Reset (any time, asynchronous): all outputs 0 except status ready=1. FSM to IDLE; counters cleared; an in-flight write is dropped. RAM contents are not reset.

## Test plan
- Write 32'hdeadbeef to 22'h011005, then read it back: memack at cycle 4 for the write; read gives memack+memdone with busin=32'hdeadbeef. bad_addr stays 0.
- Fill RAM 0x11000..0x110ff with index, then read all 256 words: every read matches. Wrap check: 0x11100 is unmapped, so bad_addr=1 and the read returns 0.
- Write CMD=0o11, CLP=0x10001, DA=0, then GO: disk_cmd/clp/da match. STATUS bit0=0 immediately after; bit0=1 exactly 16 cycles after the GO edge; disk_ops=1.
- Second GO 5 cycles after the first: STATUS bit1=1, completion time unchanged, disk_ops increments once.
- Hold memrq high for 20 cycles on one write: exactly one memack. Drop memrq and raise it on a new address: serviced normally.
- Assert reset_n=0 during WAIT of a RAM write: no memack, target word unchanged, all outputs at reset values asynchronously.
